alu_pipe_core: RTL and testbench

//  Responder (DUT side) of the alu_interface_if protocol: samples op_in/a_in/b_in whenever
//  in_valid is high and returns a (WIDTH+1)-bit result on out, qualified by out_valid.
//  Two-stage registered datapath (capture, execute) with an internal accumulator register.
//  No backpressure: one operation per clock is accepted and results return in issue order.

---
 rtl/alu_types.sv | 17 +
 rtl/alu_exec.sv | 46 ++++
 rtl/alu_pipe_core.sv | 73 +++++++
 tb/tb_alu_pipe_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_types.sv
// Shared ALU operation encoding used by the pipeline core, its interface and the testbench.
package alu_types;

   typedef enum logic [2:0] {
      ADD    = 3'd0,
      SUB    = 3'd1,
      AND_OP = 3'd2,
      OR_OP  = 3'd3,
      XOR_OP = 3'd4,
      ACC    = 3'd5,
      CLR    = 3'd6,
      RSVD   = 3'd7
   } operation_t;

   localparam int unsigned ALU_WIDTH_DEFAULT = 6;

endpackage

// File: rtl/alu_exec.sv
// Combinational execute stage: computes the result and the accumulator update for one op.
module alu_exec
   import alu_types::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
   input  operation_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH:0]   acc,
   output logic [WIDTH:0]   result,
   output logic [WIDTH:0]   acc_next,
   output logic             acc_we
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;

   // Zero-extend so the extra MSB carries the ADD carry / SUB borrow.
   assign a_ext = {1'b0, a};
   assign b_ext = {1'b0, b};

   always_comb begin
      result   = '0;
      acc_next = acc;
      acc_we   = 1'b0;
      case (op)
         ADD:    result = a_ext + b_ext;
         SUB:    result = a_ext - b_ext;
         AND_OP: result = a_ext & b_ext;
         OR_OP:  result = a_ext | b_ext;
         XOR_OP: result = a_ext ^ b_ext;
         ACC: begin
            acc_next = acc + a_ext;
            acc_we   = 1'b1;
            result   = acc_next;
         end
         CLR: begin
            acc_next = '0;
            acc_we   = 1'b1;
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_pipe_core.sv
// Two-stage ALU responder: S1 captures op/operands, S2 registers the result and owns the accumulator.
module alu_pipe_core
   import alu_types::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  operation_t       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             in_valid,
   output logic [WIDTH:0]   out,
   output logic             out_valid
);

   logic             s1_valid;
   operation_t       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH:0]   acc;

   logic [WIDTH:0]   exec_result;
   logic [WIDTH:0]   exec_acc_next;
   logic             exec_acc_we;

   // Operand regs load only on valid so don't-care inputs never reach S2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op_in;
            s1_a  <= a_in;
            s1_b  <= b_in;
         end
      end
   end

   alu_exec #(
      .WIDTH (WIDTH)
   ) u_exec (
      .op       (s1_op),
      .a        (s1_a),
      .b        (s1_b),
      .acc      (acc),
      .result   (exec_result),
      .acc_next (exec_acc_next),
      .acc_we   (exec_acc_we)
   );

   // acc commits in the same stage that reads it, so chained ACC ops see no hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         acc       <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out <= exec_result;
            if (exec_acc_we) begin
               acc <= exec_acc_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe_core.sv
// Self-checking bench for alu_pipe_core: directed cases plus random traffic against a reference model.
module tb_alu_pipe_core;
   import alu_types::*;

   localparam int W = 6;
   localparam int MOD = 1 << (W + 1);

   logic         clk;
   logic         rst;
   operation_t   op_in;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         in_valid;
   logic [W:0]   out;
   logic         out_valid;

   int errors = 0;
   int checks = 0;

   int   acc_m;
   logic exp_valid_q;
   int   exp_out_q;
   int   held_out;

   alu_pipe_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_in     (op_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_op(input int op, input int a, input int b);
      int r;
      r = 0;
      case (op)
         0: r = (a + b) % MOD;
         1: r = (a - b + MOD) % MOD;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin acc_m = (acc_m + a) % MOD; r = acc_m; end
         6: begin acc_m = 0; r = 0; end
         default: r = 0;
      endcase
      return r;
   endfunction

   // Drives one cycle of input, then checks the result of the op issued on the previous call.
   task automatic step(input logic v, input int op, input int a, input int b);
      in_valid = v;
      if (v) begin
         op_in = operation_t'(op[2:0]);
         a_in  = a[W-1:0];
         b_in  = b[W-1:0];
      end else begin
         op_in = operation_t'($urandom_range(0, 7));
         a_in  = W'($urandom);
         b_in  = W'($urandom);
      end
      @(posedge clk);
      #1;
      check("out_valid", int'(out_valid), int'(exp_valid_q));
      if (exp_valid_q) begin
         check("out", int'(out), exp_out_q);
         held_out = exp_out_q;
      end else begin
         check("out_hold", int'(out), held_out);
      end
      exp_valid_q = v;
      if (v) exp_out_q = ref_op(op, a, b);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_out", int'(out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("rst_hold_valid", int'(out_valid), 0);
      rst = 1'b0;
      acc_m       = 0;
      exp_valid_q = 1'b0;
      exp_out_q   = 0;
      held_out    = 0;
   endtask

   initial begin
      int r;
      rst         = 1'b1;
      in_valid    = 1'b0;
      op_in       = ADD;
      a_in        = '0;
      b_in        = '0;
      acc_m       = 0;
      exp_valid_q = 1'b0;
      exp_out_q   = 0;
      held_out    = 0;
      repeat (2) @(posedge clk);
      #1;
      check("por_out", int'(out), 0);
      check("por_out_valid", int'(out_valid), 0);
      rst = 1'b0;

      // Make out nonzero, then assert reset mid-cycle and re-run from clean state.
      step(1, 0, 63, 63);
      step(0, 0, 0, 0);
      do_reset();
      step(1, 0, 63, 63);
      check("add_const", exp_out_q, 'h7E);
      step(0, 0, 0, 0);

      step(1, 1, 5, 9);
      step(1, 1, 9, 5);
      step(1, 2, 'h2A, 'h0F);
      step(1, 4, 'h3F, 'h15);
      step(1, 3, 'h21, 'h12);
      step(0, 0, 0, 0);

      // Chained accumulator with wrap at 128.
      step(1, 6, 0, 0);
      step(1, 5, 40, 7);
      step(1, 5, 40, 0);
      step(1, 5, 60, 33);
      step(0, 0, 0, 0);
      check("acc_wrap_model", acc_m, 12);

      // Valid gaps: 1,1,0,1.
      step(1, 0, 3, 4);
      step(1, 0, 10, 20);
      step(0, 0, 0, 0);
      step(1, 4, 7, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Reset while two ACC ops are in flight.
      step(1, 6, 0, 0);
      step(1, 5, 10, 0);
      in_valid = 1'b1;
      op_in    = ACC;
      a_in     = 6'd10;
      do_reset();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 5, 5, 0);
      step(0, 0, 0, 0);
      check("post_rst_acc", held_out, 5);

      // Reserved op leaves acc untouched.
      step(1, 7, 'h3F, 'h3F);
      step(1, 5, 1, 0);
      step(0, 0, 0, 0);
      check("rsvd_then_acc", held_out, 6);

      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) do_reset();
         else step(r > 20, $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63));
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
